// File: rtl/fir_sym_cfg.sv
// Symmetric even-length FIR for the ADC sample path: pre-add, multiply, registered
// adder tree and round/saturate, with a shadow/active coefficient bank and atomic swap.
module fir_sym_cfg #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NTAPS     = 28,
  parameter int unsigned COEF_FRAC = 15,
  parameter int unsigned OUT_W     = 12
) (
  input  logic                              i_fpga_clk,
  input  logic                              i_rst_n,
  input  logic signed [DATA_W-1:0]          i_din,
  input  logic                              i_din_vld,
  input  logic                              i_coef_wr,
  input  logic        [$clog2(NTAPS/2)-1:0] i_coef_addr,
  input  logic signed [COEF_W-1:0]          i_coef_data,
  input  logic                              i_coef_swap,
  output logic signed [OUT_W-1:0]           o_dout,
  output logic                              o_dout_vld,
  output logic                              o_sat
);

  localparam int unsigned HALF   = NTAPS / 2;
  localparam int unsigned AW     = $clog2(HALF);
  localparam int unsigned T      = $clog2(HALF);
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + T;

  localparam logic signed [COEF_W-1:0] COEF_DEF = COEF_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0]    RND_C    = (ACC_W + 1)'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W:0]    SAT_MAX  = {{(ACC_W + 2 - OUT_W){1'b0}},
                                                   {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0]    SAT_MIN  = {{(ACC_W + 2 - OUT_W){1'b1}},
                                                   {(OUT_W - 1){1'b0}}};

  // Operand count at each adder-tree level; level 0 holds the products.
  function automatic int unsigned lvl_cnt(input int unsigned lvl);
    int unsigned n;
    n = HALF;
    for (int unsigned i = 0; i < lvl; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Coefficient banks
  logic signed [COEF_W-1:0] r_coef_sh  [HALF];
  logic signed [COEF_W-1:0] r_coef_act [HALF];

  // Out-of-range addresses match no entry and are dropped.
  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < HALF; k++) begin
        r_coef_sh[k] <= (k == HALF - 1) ? COEF_DEF : '0;
      end
    end else begin
      for (int unsigned k = 0; k < HALF; k++) begin
        if (i_coef_wr && (i_coef_addr == AW'(k))) r_coef_sh[k] <= i_coef_data;
      end
    end
  end

  // Swap copies the pre-edge shadow, so a same-cycle write lands in shadow only.
  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < HALF; k++) begin
        r_coef_act[k] <= (k == HALF - 1) ? COEF_DEF : '0;
      end
    end else if (i_coef_swap) begin
      for (int unsigned k = 0; k < HALF; k++) r_coef_act[k] <= r_coef_sh[k];
    end
  end

  // S1: tap delay line, shifts only on accepted samples
  logic signed [DATA_W-1:0] r_tap [NTAPS];
  logic                     r_s1_vld;

  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_vld <= 1'b0;
      for (int unsigned k = 0; k < NTAPS; k++) r_tap[k] <= '0;
    end else begin
      r_s1_vld <= i_din_vld;
      if (i_din_vld) begin
        r_tap[0] <= i_din;
        for (int unsigned k = 1; k < NTAPS; k++) r_tap[k] <= r_tap[k-1];
      end
    end
  end

  // S2: fold symmetric tap pairs
  logic signed [PRE_W-1:0] r_pre [HALF];
  logic                    r_pre_vld;

  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre_vld <= 1'b0;
      for (int unsigned k = 0; k < HALF; k++) r_pre[k] <= '0;
    end else begin
      r_pre_vld <= r_s1_vld;
      for (int unsigned k = 0; k < HALF; k++) begin
        r_pre[k] <= PRE_W'(r_tap[k]) + PRE_W'(r_tap[NTAPS-1-k]);
      end
    end
  end

  // S3 multiply (level 0) followed by T registered adder levels, one bit of growth each.
  for (genvar l = 0; l <= T; l++) begin : g_lvl
    localparam int unsigned N = lvl_cnt(l);
    localparam int unsigned W = PROD_W + l;

    logic signed [W-1:0] r_sum [N];
    logic                r_vld;

    if (l == 0) begin : g_mul
      always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld <= 1'b0;
          for (int unsigned k = 0; k < N; k++) r_sum[k] <= '0;
        end else begin
          r_vld <= r_pre_vld;
          for (int unsigned k = 0; k < N; k++) begin
            r_sum[k] <= W'(r_pre[k]) * W'(r_coef_act[k]);
          end
        end
      end
    end else begin : g_add
      localparam int unsigned NP = lvl_cnt(l - 1);

      // An odd trailing operand is paired with zero, i.e. sign-extended and passed on.
      logic signed [W-1:0] w_in [2*N];

      for (genvar j = 0; j < 2 * N; j++) begin : g_in
        if (j < NP) begin : g_src
          assign w_in[j] = W'(g_lvl[l-1].r_sum[j]);
        end else begin : g_pad
          assign w_in[j] = '0;
        end
      end

      always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_vld <= 1'b0;
          for (int unsigned k = 0; k < N; k++) r_sum[k] <= '0;
        end else begin
          r_vld <= g_lvl[l-1].r_vld;
          for (int unsigned k = 0; k < N; k++) r_sum[k] <= w_in[2*k] + w_in[2*k+1];
        end
      end
    end
  end

  // Round half up, then clip to the output range
  logic signed [ACC_W:0]   w_rnd;
  logic signed [ACC_W:0]   w_shr;
  logic signed [OUT_W-1:0] w_out;
  logic                    w_sat;

  assign w_rnd = (ACC_W + 1)'(g_lvl[T].r_sum[0]) + RND_C;
  assign w_shr = w_rnd >>> COEF_FRAC;

  always_comb begin
    w_out = w_shr[OUT_W-1:0];
    w_sat = 1'b0;
    if (w_shr > SAT_MAX) begin
      w_out = SAT_MAX[OUT_W-1:0];
      w_sat = 1'b1;
    end else if (w_shr < SAT_MIN) begin
      w_out = SAT_MIN[OUT_W-1:0];
      w_sat = 1'b1;
    end
  end

  always_ff @(posedge i_fpga_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dout     <= '0;
      o_dout_vld <= 1'b0;
      o_sat      <= 1'b0;
    end else begin
      o_dout_vld <= g_lvl[T].r_vld;
      o_sat      <= g_lvl[T].r_vld & w_sat;
      if (g_lvl[T].r_vld) o_dout <= w_out;
    end
  end

endmodule

// File: tb/tb_fir_sym_cfg.sv
// Directed bench for fir_sym_cfg: impulse responses, strobe gating, rounding,
// saturation, shadow/swap timing and mid-stream reset, against hand-computed values.
module tb_fir_sym_cfg;

  logic               clk = 1'b0;
  logic               rst_n;
  logic signed [11:0] din;
  logic               din_vld;
  logic               coef_wr;
  logic        [3:0]  coef_addr;
  logic signed [15:0] coef_data;
  logic               coef_swap;
  logic signed [11:0] dout;
  logic               dout_vld;
  logic               sat;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned sat_glitch = 0;

  logic signed [11:0] q_dout [$];
  logic               q_sat  [$];
  int unsigned        q_cyc  [$];
  int unsigned        in_cyc [$];

  fir_sym_cfg dut (
    .i_fpga_clk  (clk),
    .i_rst_n     (rst_n),
    .i_din       (din),
    .i_din_vld   (din_vld),
    .i_coef_wr   (coef_wr),
    .i_coef_addr (coef_addr),
    .i_coef_data (coef_data),
    .i_coef_swap (coef_swap),
    .o_dout      (dout),
    .o_dout_vld  (dout_vld),
    .o_sat       (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dout_vld) begin
      q_dout.push_back(dout);
      q_sat.push_back(sat);
      q_cyc.push_back(cyc);
    end else if (sat) begin
      sat_glitch++;
    end
  end

  task automatic drive(input logic signed [11:0] d, input logic v, input logic wr = 1'b0,
                       input logic [3:0] a = 4'd0, input logic signed [15:0] c = 16'sd0,
                       input logic sw = 1'b0);
    @(negedge clk);
    din = d; din_vld = v; coef_wr = wr; coef_addr = a; coef_data = c; coef_swap = sw;
    if (v) in_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(12'sd0, 1'b0);
  endtask

  task automatic clear_q();
    q_dout.delete(); q_sat.delete(); q_cyc.delete(); in_cyc.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; din = '0; din_vld = 1'b0; coef_wr = 1'b0; coef_swap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One impulse followed by zeros; gap idle cycles after every sample carry junk data.
  task automatic impulse(input logic signed [11:0] amp, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      drive((i == 0) ? amp : 12'sd0, 1'b1);
      repeat (gap) drive(12'sh5A5, 1'b0);
    end
    idle(12);
  endtask

  function automatic logic signed [11:0] out_at(input int i);
    if (i < q_dout.size()) return q_dout[i];
    return 'x;
  endfunction

  function automatic logic sat_at(input int i);
    if (i < q_sat.size()) return q_sat[i];
    return 1'bx;
  endfunction

  function automatic int lat_at(input int i);
    if (i < q_cyc.size() && i < in_cyc.size()) return int'(q_cyc[i]) - int'(in_cyc[i]);
    return -1;
  endfunction

  task automatic test_reset();
    #1;
    n_vec++;
    if (dout !== 12'sd0 || dout_vld !== 1'b0 || sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: dout=%0d vld=%b sat=%b, want 0 0 0", dout, dout_vld, sat);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(10);
    n_vec++;
    if (q_dout.size() != 0 || dout !== 12'sd0) begin
      n_err++;
      $display("FAIL reset_idle: outputs=%0d dout=%0d, want 0 0", q_dout.size(), dout);
    end
  endtask

  task automatic test_default_impulse();
    logic signed [11:0] exp;
    apply_reset();
    clear_q();
    impulse(12'sd1000, 30, 0);
    n_vec++;
    if (q_dout.size() != 30) begin
      n_err++;
      $display("FAIL dflt_count: got %0d outputs, want 30", q_dout.size());
    end
    for (int i = 0; i < 30; i++) begin
      exp = (i == 13 || i == 14) ? 12'sd500 : 12'sd0;
      n_vec++;
      if (out_at(i) !== exp) begin
        n_err++;
        $display("FAIL dflt_y[%0d]: got %0d, want %0d", i, out_at(i), exp);
      end
      n_vec++;
      if (lat_at(i) != 8) begin
        n_err++;
        $display("FAIL dflt_lat[%0d]: got %0d, want 8", i, lat_at(i));
      end
    end
  endtask

  task automatic test_strobe_gating();
    logic signed [11:0] exp;
    apply_reset();
    clear_q();
    impulse(12'sd1000, 30, 2);
    n_vec++;
    if (q_dout.size() != 30) begin
      n_err++;
      $display("FAIL gate_count: got %0d outputs, want 30", q_dout.size());
    end
    for (int i = 0; i < 30; i++) begin
      exp = (i == 13 || i == 14) ? 12'sd500 : 12'sd0;
      n_vec++;
      if (out_at(i) !== exp) begin
        n_err++;
        $display("FAIL gate_y[%0d]: got %0d, want %0d", i, out_at(i), exp);
      end
      n_vec++;
      if (lat_at(i) != 8) begin
        n_err++;
        $display("FAIL gate_lat[%0d]: got %0d, want 8", i, lat_at(i));
      end
    end
  endtask

  task automatic test_rounding();
    logic signed [11:0] val [4] = '{12'sd1, 12'sd0, 12'sd4, -12'sd2};
    logic signed [11:0] exp;
    apply_reset();
    drive(12'sd0, 1'b0, 1'b1, 4'd13, 16'sd16384);
    drive(12'sd0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    idle(2);
    clear_q();
    impulse(12'sd1, 30, 0);
    impulse(-12'sd1, 30, 0);
    drive(12'sd0, 1'b0, 1'b1, 4'd13, 16'sd24576);
    drive(12'sd0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    idle(2);
    impulse(12'sd5, 30, 0);
    impulse(-12'sd3, 30, 0);
    n_vec++;
    if (q_dout.size() != 120) begin
      n_err++;
      $display("FAIL rnd_count: got %0d outputs, want 120", q_dout.size());
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 30; i++) begin
        exp = (i == 13 || i == 14) ? val[r] : 12'sd0;
        n_vec++;
        if (out_at(r * 30 + i) !== exp) begin
          n_err++;
          $display("FAIL rnd_y[%0d][%0d]: got %0d, want %0d", r, i, out_at(r * 30 + i), exp);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [11:0] amp [3] = '{12'sd2047, -12'sd2048, 12'sd0};
    logic               esat [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    for (int k = 0; k < 14; k++) drive(12'sd0, 1'b0, 1'b1, 4'(k), 16'sd2047);
    drive(12'sd0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    idle(2);
    clear_q();
    sat_glitch = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 40; i++) drive(amp[r], 1'b1);
    end
    idle(12);
    for (int r = 0; r < 3; r++) begin
      for (int i = 28; i < 40; i++) begin
        n_vec++;
        if (out_at(r * 40 + i) !== amp[r] || sat_at(r * 40 + i) !== esat[r]) begin
          n_err++;
          $display("FAIL sat_y[%0d][%0d]: got %0d sat=%b, want %0d sat=%b", r, i,
                   out_at(r * 40 + i), sat_at(r * 40 + i), amp[r], esat[r]);
        end
      end
    end
    n_vec++;
    if (sat_glitch != 0) begin
      n_err++;
      $display("FAIL sat_idle: o_sat high without strobe %0d times, want 0", sat_glitch);
    end
  endtask

  task automatic test_shadow_isolation();
    logic signed [11:0] exp;
    apply_reset();
    drive(12'sd0, 1'b0, 1'b1, 4'd0, 16'sd32767);
    drive(12'sd0, 1'b0, 1'b1, 4'd13, 16'sd0);
    idle(2);
    clear_q();
    impulse(12'sd1000, 30, 0);
    drive(12'sd0, 1'b0, 1'b1, 4'd5, 16'sd8192, 1'b1);
    idle(2);
    impulse(12'sd1000, 30, 0);
    drive(12'sd0, 1'b0, 1'b1, 4'd14, 16'sh7FFF);
    drive(12'sd0, 1'b0, 1'b1, 4'd15, 16'sh7FFF);
    drive(12'sd0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    idle(2);
    impulse(12'sd1000, 30, 0);
    n_vec++;
    if (q_dout.size() != 90) begin
      n_err++;
      $display("FAIL shadow_count: got %0d outputs, want 90", q_dout.size());
    end
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 30; i++) begin
        exp = 12'sd0;
        if (r == 0 && (i == 13 || i == 14)) exp = 12'sd500;
        if (r != 0 && (i == 0 || i == 27)) exp = 12'sd1000;
        if (r == 2 && (i == 5 || i == 22)) exp = 12'sd250;
        n_vec++;
        if (out_at(r * 30 + i) !== exp) begin
          n_err++;
          $display("FAIL shadow_y[%0d][%0d]: got %0d, want %0d", r, i, out_at(r * 30 + i), exp);
        end
      end
    end
  endtask

  task automatic test_swap_stream();
    logic signed [11:0] exp;
    apply_reset();
    drive(12'sd0, 1'b0, 1'b1, 4'd13, 16'sd8192);
    idle(2);
    clear_q();
    for (int j = 0; j < 40; j++) drive(12'sd1000, 1'b1, 1'b0, 4'd0, 16'sd0, (j == 35));
    idle(12);
    for (int j = 20; j < 40; j++) begin
      exp = (j <= 33) ? 12'sd1000 : 12'sd500;
      n_vec++;
      if (out_at(j) !== exp) begin
        n_err++;
        $display("FAIL swap_y[%0d]: got %0d, want %0d", j, out_at(j), exp);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic signed [11:0] exp;
    apply_reset();
    drive(12'sd0, 1'b0, 1'b1, 4'd13, 16'sd8192, 1'b0);
    drive(12'sd0, 1'b0, 1'b0, 4'd0, 16'sd0, 1'b1);
    idle(2);
    clear_q();
    for (int j = 0; j < 22; j++) drive(12'sd1000, 1'b1);
    idle(2);
    // Samples 0..16 have emerged by this edge; 17..21 are still in flight.
    @(negedge clk);
    #2;
    n_vec++;
    if (dout !== 12'sd500) begin
      n_err++;
      $display("FAIL mid_pre: dout=%0d, want 500", dout);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (dout !== 12'sd0 || dout_vld !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: dout=%0d vld=%b, want 0 0", dout, dout_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(15);
    n_vec++;
    if (q_dout.size() != 17 || dout !== 12'sd0) begin
      n_err++;
      $display("FAIL mid_drop: outputs=%0d dout=%0d, want 17 0", q_dout.size(), dout);
    end
    clear_q();
    impulse(12'sd1000, 30, 0);
    for (int i = 0; i < 30; i++) begin
      exp = (i == 13 || i == 14) ? 12'sd500 : 12'sd0;
      n_vec++;
      if (out_at(i) !== exp) begin
        n_err++;
        $display("FAIL mid_rerun_y[%0d]: got %0d, want %0d", i, out_at(i), exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; din = '0; din_vld = 1'b0; coef_wr = 1'b0; coef_addr = '0;
    coef_data = '0; coef_swap = 1'b0;
    test_reset();
    test_default_impulse();
    test_strobe_gating();
    test_rounding();
    test_saturation();
    test_shadow_isolation();
    test_swap_stream();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
